// File: rtl/cpld_spi_responder_if.sv
// cpld_spi_responder_if: DSP-side SPI pins (mode 0, active-low chip select).
// The DSP is the master; the CPLD responder uses the slave modport.
interface cpld_spi_responder_if;
  logic spi_clk;
  logic spi_mosi;
  logic spi_cs_INV;
  logic spi_miso;

  modport master (
    output spi_clk,
    output spi_mosi,
    output spi_cs_INV,
    input  spi_miso
  );

  modport slave (
    input  spi_clk,
    input  spi_mosi,
    input  spi_cs_INV,
    output spi_miso
  );
endinterface

// File: rtl/cpld_spi_responder.sv
// cpld_spi_responder: oversampled SPI mode-0 register responder for the DSP.
// 16-bit frames, MSB first: R/W (1 = read), 7-bit address, 8-bit data.
// All logic runs on sysclk; the SPI pins are only ever sampled.
// Optional build macro CPLD_SPI_ERRCNT_EN adds the aborted-frame counter at 0x04.
module cpld_spi_responder #(
  parameter logic [7:0] ID_VALUE   = 8'hA5,
  parameter logic [7:0] CTRL_RESET = 8'h00
) (
  input  logic                       sysclk,
  input  logic                       reset_INV,
  cpld_spi_responder_if.slave        spi,
  input  logic [7:0]                 status_in,
  output logic [7:0]                 ctrl_out,
  output logic                       wr_strobe,
  output logic                       frame_active
);

  typedef enum logic [1:0] {
    ST_OVER = 2'd0,
    ST_IDLE = 2'd1,
    ST_ADDR = 2'd2,
    ST_DATA = 2'd3
  } state_t;

  state_t      state_r, state_nxt;
  logic [4:0]  cnt_r, cnt_nxt;

  logic        clk_meta_r, clk_sync_r, clk_dly_r;
  logic        mosi_meta_r, mosi_sync_r;
  logic        cs_meta_r, cs_sync_r;
  logic [1:0]  sync_ok_r;

  logic        rise_s, fall_s;
  logic        shift_in_s, latch_s, drive_s, commit_s, abort_s;

  logic [6:0]  shift_r;
  logic        rw_r;
  logic [6:0]  addr_r;
  logic [7:0]  rd_shift_r;
  logic        miso_r;
  logic [6:0]  addr_in_s;
  logic [7:0]  wr_data_s;
  logic [7:0]  rd_val_s;
  logic [7:0]  errcnt_s;

  logic [7:0]  ctrl_r, scratch_r;
  logic        wr_strobe_r, frame_active_r;

  // Two-flop synchronizers on the SPI pins plus a delay flop for edge detect;
  // sync_ok_r marks when the CS synchronizer holds real pin data after reset.
  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      clk_meta_r  <= 1'b0;
      clk_sync_r  <= 1'b0;
      clk_dly_r   <= 1'b0;
      mosi_meta_r <= 1'b0;
      mosi_sync_r <= 1'b0;
      cs_meta_r   <= 1'b1;
      cs_sync_r   <= 1'b1;
      sync_ok_r   <= 2'b00;
    end else begin
      clk_meta_r  <= spi.spi_clk;
      clk_sync_r  <= clk_meta_r;
      clk_dly_r   <= clk_sync_r;
      mosi_meta_r <= spi.spi_mosi;
      mosi_sync_r <= mosi_meta_r;
      cs_meta_r   <= spi.spi_cs_INV;
      cs_sync_r   <= cs_meta_r;
      sync_ok_r   <= {sync_ok_r[0], 1'b1};
    end
  end

  assign rise_s    = clk_sync_r & ~clk_dly_r;
  assign fall_s    = ~clk_sync_r & clk_dly_r;
  assign addr_in_s = {shift_r[5:0], mosi_sync_r};
  assign wr_data_s = {shift_r[6:0], mosi_sync_r};

  // Frame state register and bit counter.
  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      state_r <= ST_OVER;
      cnt_r   <= 5'd0;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
    end
  end

  // Next-state and datapath controls; the 16th rise outranks a same-cycle CS release.
  always_comb begin
    state_nxt  = state_r;
    cnt_nxt    = cnt_r;
    shift_in_s = 1'b0;
    latch_s    = 1'b0;
    drive_s    = 1'b0;
    commit_s   = 1'b0;
    abort_s    = 1'b0;
    case (state_r)
      ST_OVER: begin
        if (sync_ok_r[1] && cs_sync_r) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_OVER;
        end
      end
      ST_IDLE: begin
        cnt_nxt = 5'd0;
        if (!cs_sync_r) begin
          state_nxt = ST_ADDR;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (cs_sync_r) begin
          abort_s   = (cnt_r != 5'd0);
          state_nxt = ST_IDLE;
          cnt_nxt   = 5'd0;
        end else if (rise_s && (cnt_r < 5'd8)) begin
          shift_in_s = 1'b1;
          latch_s    = (cnt_r == 5'd7);
          cnt_nxt    = cnt_r + 5'd1;
        end else if (fall_s && (cnt_r == 5'd8)) begin
          drive_s   = 1'b1;
          state_nxt = ST_DATA;
        end else begin
          state_nxt = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (rise_s && (cnt_r == 5'd15)) begin
          commit_s  = ~rw_r;
          cnt_nxt   = 5'd16;
          state_nxt = ST_OVER;
        end else if (cs_sync_r) begin
          abort_s   = 1'b1;
          state_nxt = ST_IDLE;
          cnt_nxt   = 5'd0;
        end else if (rise_s) begin
          shift_in_s = 1'b1;
          cnt_nxt    = cnt_r + 5'd1;
        end else if (fall_s) begin
          drive_s = 1'b1;
        end else begin
          state_nxt = ST_DATA;
        end
      end
      default: begin
        state_nxt = ST_OVER;
        cnt_nxt   = 5'd0;
      end
    endcase
  end

  // Register read mux, evaluated on the address byte as it completes.
  always_comb begin
    rd_val_s = 8'h00;
    case (addr_in_s)
      7'h00:   rd_val_s = ID_VALUE;
      7'h01:   rd_val_s = status_in;
      7'h02:   rd_val_s = ctrl_r;
      7'h03:   rd_val_s = scratch_r;
      7'h04:   rd_val_s = errcnt_s;
      default: rd_val_s = 8'h00;
    endcase
  end

  // MOSI shifter, header latch, read shifter and MISO driver.
  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      shift_r    <= 7'd0;
      rw_r       <= 1'b0;
      addr_r     <= 7'd0;
      rd_shift_r <= 8'h00;
      miso_r     <= 1'b0;
    end else begin
      if (shift_in_s) begin
        shift_r <= {shift_r[5:0], mosi_sync_r};
      end else begin
        shift_r <= shift_r;
      end
      if (latch_s) begin
        rw_r       <= shift_r[6];
        addr_r     <= addr_in_s;
        rd_shift_r <= rd_val_s;
      end else if (drive_s) begin
        rd_shift_r <= {rd_shift_r[6:0], 1'b0};
      end else begin
        rd_shift_r <= rd_shift_r;
      end
      if (cs_sync_r || (state_nxt == ST_OVER) || (state_nxt == ST_IDLE)) begin
        miso_r <= 1'b0;
      end else if (drive_s) begin
        miso_r <= rd_shift_r[7];
      end else begin
        miso_r <= miso_r;
      end
    end
  end

  // Writable registers, commit strobe and frame-activity flag.
  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      ctrl_r         <= CTRL_RESET;
      scratch_r      <= 8'h00;
      wr_strobe_r    <= 1'b0;
      frame_active_r <= 1'b0;
    end else begin
      wr_strobe_r    <= commit_s;
      frame_active_r <= (state_nxt == ST_ADDR) || (state_nxt == ST_DATA);
      if (commit_s && (addr_r == 7'h02)) begin
        ctrl_r <= wr_data_s;
      end else begin
        ctrl_r <= ctrl_r;
      end
      if (commit_s && (addr_r == 7'h03)) begin
        scratch_r <= wr_data_s;
      end else begin
        scratch_r <= scratch_r;
      end
    end
  end

`ifdef CPLD_SPI_ERRCNT_EN
  logic [7:0] errcnt_r;

  // Aborted-frame counter: saturates at 0xFF, any write clears it (clear wins).
  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      errcnt_r <= 8'h00;
    end else if (commit_s && (addr_r == 7'h04)) begin
      errcnt_r <= 8'h00;
    end else if (abort_s && (errcnt_r != 8'hFF)) begin
      errcnt_r <= errcnt_r + 8'h01;
    end else begin
      errcnt_r <= errcnt_r;
    end
  end

  assign errcnt_s = errcnt_r;
`else
  logic errcnt_unused_s;
  assign errcnt_unused_s = abort_s;
  assign errcnt_s        = 8'h00;
`endif

  assign spi.spi_miso = miso_r & ~cs_sync_r;
  assign ctrl_out     = ctrl_r;
  assign wr_strobe    = wr_strobe_r;
  assign frame_active = frame_active_r;

endmodule

// File: tb/tb_cpld_spi_responder.sv
// tb_cpld_spi_responder: directed SPI frames against cpld_spi_responder with
// hand-computed expectations; honours CPLD_SPI_ERRCNT_EN for address 0x04.
module tb_cpld_spi_responder;
`ifdef CPLD_SPI_ERRCNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       sysclk = 1'b0;
  logic       reset_INV;
  logic [7:0] status_in;
  logic [7:0] ctrl_out;
  logic       wr_strobe;
  logic       frame_active;

  int pass_cnt   = 0;
  int total_cnt  = 0;
  int strobe_cnt = 0;
  int strobe_ref;

  logic [31:0] rx;
  logic [7:0]  rd;
  logic [15:0] w;
  logic        m;

  cpld_spi_responder_if spi ();

  cpld_spi_responder dut (
    .sysclk       (sysclk),
    .reset_INV    (reset_INV),
    .spi          (spi),
    .status_in    (status_in),
    .ctrl_out     (ctrl_out),
    .wr_strobe    (wr_strobe),
    .frame_active (frame_active)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) begin
    if (wr_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  // One SPI bit: set MOSI, sample MISO at the end of the low phase, pulse SCK.
  task automatic spi_bit(input logic b, output logic miso, input bit hook);
    spi.spi_mosi = b;
    wait_cyc(5);
    miso = spi.spi_miso;
    spi.spi_clk = 1'b1;
    wait_cyc(5);
    if (hook) status_in = 8'hFF;
    spi.spi_clk = 1'b0;
  endtask

  // Full frame of nbits, first bit is tx[nbits-1]; rx collects MISO per bit.
  task automatic spi_frame(input int nbits, input logic [31:0] tx, input bit status_hook,
                           output logic [31:0] rxo);
    logic b;
    rxo = 32'h0;
    spi.spi_cs_INV = 1'b0;
    wait_cyc(5);
    for (int i = 0; i < nbits; i++) begin
      spi_bit(tx[nbits-1-i], b, status_hook && (i == 7));
      rxo = {rxo[30:0], b};
    end
    wait_cyc(5);
    spi.spi_cs_INV = 1'b1;
    wait_cyc(10);
  endtask

  task automatic spi_read(input logic [6:0] a, output logic [7:0] d);
    logic [31:0] r;
    spi_frame(16, {16'h0000, 1'b1, a, 8'h00}, 1'b0, r);
    d = r[7:0];
  endtask

  task automatic spi_write(input logic [6:0] a, input logic [7:0] d);
    logic [31:0] r;
    spi_frame(16, {16'h0000, 1'b0, a, d}, 1'b0, r);
  endtask

  initial begin
    reset_INV      = 1'b0;
    spi.spi_clk    = 1'b0;
    spi.spi_mosi   = 1'b0;
    spi.spi_cs_INV = 1'b1;
    status_in      = 8'h3C;
    wait_cyc(3);
    check("rst_miso", {31'h0, spi.spi_miso}, 32'h0);
    check("rst_ctrl", {24'h0, ctrl_out}, 32'h00);
    check("rst_wr_strobe", {31'h0, wr_strobe}, 32'h0);
    check("rst_frame_active", {31'h0, frame_active}, 32'h0);
    reset_INV = 1'b1;
    wait_cyc(5);

    // Read ID
    spi_frame(16, 32'h0000_8000, 1'b0, rx);
    check("read_id", rx[15:0], 32'h00A5);
    check("read_id_ctrl", {24'h0, ctrl_out}, 32'h00);

    // Write ctrl then read back
    strobe_ref = strobe_cnt;
    spi_write(7'h02, 8'h5C);
    check("wr_ctrl_out", {24'h0, ctrl_out}, 32'h5C);
    check("wr_ctrl_strobes", strobe_cnt - strobe_ref, 32'd1);
    spi_read(7'h02, rd);
    check("rd_ctrl", {24'h0, rd}, 32'h5C);
    check("idle_frame_active", {31'h0, frame_active}, 32'h0);

    // Status captured at the 8th rise
    status_in = 8'h3C;
    spi_frame(16, 32'h0000_8100, 1'b1, rx);
    check("rd_status", rx[7:0], 32'h3C);

    // Unmapped address reads zero
    spi_read(7'h55, rd);
    check("rd_unmapped", {24'h0, rd}, 32'h00);

    // Abort after 11 bits of write 0x03 = 0x77
    w = 16'h0377;
    strobe_ref = strobe_cnt;
    spi_frame(11, {16'h0000, w} >> 5, 1'b0, rx);
    check("abort_no_strobe", strobe_cnt - strobe_ref, 32'd0);
    spi_read(7'h03, rd);
    check("abort_scratch", {24'h0, rd}, 32'h00);
    spi_read(7'h04, rd);
    check("abort_errcnt", {24'h0, rd}, ERR_EN ? 32'h01 : 32'h00);

    // 300 one-bit aborts saturate the counter
    for (int k = 0; k < 300; k++) spi_frame(1, 32'h0, 1'b0, rx);
    spi_read(7'h04, rd);
    check("errcnt_sat", {24'h0, rd}, ERR_EN ? 32'hFF : 32'h00);
    strobe_ref = strobe_cnt;
    spi_write(7'h04, 8'h33);
    check("errcnt_clr_strobe", strobe_cnt - strobe_ref, 32'd1);
    spi_read(7'h04, rd);
    check("errcnt_clr", {24'h0, rd}, 32'h00);

    // Reset pulse at bit 5 with CS held low, then 11 more clocks
    strobe_ref = strobe_cnt;
    w = 16'h0355;
    spi.spi_cs_INV = 1'b0;
    wait_cyc(5);
    for (int i = 0; i < 5; i++) begin
      spi_bit(w[15-i], m, 1'b0);
      if (i == 2) check("mid_frame_active", {31'h0, frame_active}, 32'h1);
    end
    reset_INV = 1'b0;
    wait_cyc(2);
    reset_INV = 1'b1;
    check("reset_ctrl", {24'h0, ctrl_out}, 32'h00);
    for (int i = 5; i < 16; i++) spi_bit(w[15-i], m, 1'b0);
    check("ignored_frame_active", {31'h0, frame_active}, 32'h0);
    wait_cyc(5);
    spi.spi_cs_INV = 1'b1;
    wait_cyc(10);
    check("reset_no_strobe", strobe_cnt - strobe_ref, 32'd0);
    spi_read(7'h04, rd);
    check("reset_no_error", {24'h0, rd}, 32'h00);
    spi_read(7'h03, rd);
    check("reset_scratch", {24'h0, rd}, 32'h00);

    // 20-bit write frame: trailing bits ignored, MISO stays low
    strobe_ref = strobe_cnt;
    spi_frame(20, {12'h000, 16'h03A1, 4'hF}, 1'b0, rx);
    check("trail_miso", {28'h0, rx[3:0]}, 32'h0);
    check("trail_strobe", strobe_cnt - strobe_ref, 32'd1);
    spi_read(7'h03, rd);
    check("trail_scratch", {24'h0, rd}, 32'hA1);
    check("final_ctrl", {24'h0, ctrl_out}, 32'h00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/cpld_spi_responder.md
# cpld_spi_responder

SPI mode-0 register responder that lets the DSP, as SPI initiator on its second chip select, read CPLD status and write CPLD control bits. It sits between the DSP SPI pins (bank 2) and top-level status/control nets, and all of it runs on the internal UFM oscillator clock. SPI pins are oversampled; no logic is clocked by the SPI clock.

## Interface
- `ID_VALUE`, default `8'hA5`: constant returned at address 0x00.
- `CTRL_RESET`, default `8'h00`: reset value of the control register.

Ports:
- `sysclk`  in  1  UFM oscillator clock, 3.3–5.5 MHz.
- `reset_INV`  in  1  one clock; reset is asynchronous and active-low.
- `spi_clk`  in  1  SPI clock from the DSP, idle low.
- `spi_mosi`  in  1  SPI data from the DSP.
- `spi_cs_INV`  in  1  SPI chip select from the DSP, active-low.
- `spi_miso`  out  1  SPI data to the DSP; driven 0 when not selected.
- `status_in`  in  8  live status bits (power-good, sequencer state).
- `ctrl_out`  out  8  control register contents.
- `wr_strobe`  out  1  one-cycle pulse when any register write commits.
- `frame_active`  out  1  high while in ADDR or DATA.

## Operation
- Each of `spi_clk`, `spi_mosi` and `spi_cs_INV` passes through a 2-flop synchronizer.
  - Reset values: clk 0, mosi 0, cs 1.
- A third flop on the synced clock gives rise and fall detect.
- Frame format, 16 bits, MSB first:
  - bit 15 = R/W, where 1 means read.
  - bits 14:8 = address.
  - bits 7:0 = write data on MOSI, or read data on MISO.
- MOSI is sampled on detected rises. MISO changes on detected falls.
- Registers:
  - 0x00 reads `ID_VALUE`.
  - 0x01 reads `status_in`, captured in the cycle the 8th rise is processed.
  - 0x02 is `ctrl_out`, read/write.
  - 0x03 is scratch, read/write.
  - 0x04 is the error counter. Reading returns the count; any write clears it to 0.
  - All other addresses read 0x00 and ignore writes.
- States:
  - OVER: reset state. Waits for synced CS high, then goes to IDLE. Exiting OVER never counts an error.
  - IDLE: bit counter = 0 and `spi_miso` = 0. Synced CS low goes to ADDR.
  - ADDR: shifts in 8 bits. On the 8th rise, latches R/W and address, and loads the read shifter with the register value. The next fall drives read bit 7, then goes to DATA.
  - DATA: shifts 8 bits. Read bits 6..0 are driven on the subsequent falls. The 16th rise commits a write, if any: register updates and `wr_strobe` pulses the following cycle. Then goes to OVER.
  - In OVER after a complete frame, extra clocks are ignored and MISO is 0.
- CS high while in ADDR or DATA (bit count 1–15) is an aborted frame:
  - no write occurs;
  - the error counter increments, saturating at 0xFF;
  - state returns to IDLE.
- CS high in ADDR with 0 bits received returns to IDLE with no error.
- `spi_miso` is forced to 0 in the cycle synced CS is high.
- Reset values: `spi_miso` 0, `ctrl_out` = `CTRL_RESET`, scratch 0, error counter 0, `wr_strobe` 0, `frame_active` 0, state OVER.

## Timing
- Pin-to-detect latency: 3 `sysclk` edges for a clock edge, CS or data.
- MISO update: at most 4 `sysclk` cycles after a falling `spi_clk` pin edge.
- Constraints on the initiator:
  - SCK high and low time ≥ 4 `sysclk` periods each (≤ 400 kHz at 3.3 MHz).
  - CS low to first rise ≥ 4 periods.
  - Last fall to CS high ≥ 4 periods.
- Simultaneous events:
  - If the 16th rise and CS deassert are detected in the same cycle, the rise is processed first, so the write commits.
  - If an error-counter write and an abort happen in the same cycle, the clear wins.
- Reset asserted mid-frame: state goes to OVER. The remainder of that frame is ignored until CS is seen high.

## Configuration
- `CPLD_SPI_ERRCNT_EN` defined: the error counter is built and address 0x04 behaves as above.
- Undefined: no counter logic; 0x04 reads 0x00 and writes to it are ignored (`wr_strobe` still pulses).

## Test plan
- Read 0x00, frame 0x80 0x00 -> MISO byte 0xA5; `ctrl_out` unchanged at 0x00.
- Write 0x02 = 0x5C, then read 0x02 -> `ctrl_out` = 0x5C one cycle after the 16th rise; exactly one `wr_strobe` pulse; readback 0x5C.
- `status_in` = 0x3C until the 8th rise, then 0xFF; read 0x01 -> returns 0x3C.
- Abort: CS high after 11 bits of a write of 0x03 = 0x77 -> scratch stays 0x00; error counter reads 0x01. 300 aborts -> reads 0xFF; a write to 0x04 clears it to 0x00.
- Reset pulse at bit 5 with CS held low, then 11 more clocks -> no write and no error count; the next full frame works normally.
- 20-bit write frame 0x03 = 0xA1 -> scratch = 0xA1; trailing bits ignored; MISO 0.
